// File: rtl/sound_scheduler.sv
// Fixed-priority tone scheduler: grants one requester at a time, plays its note for a
// programmed number of milliseconds, then inserts a silent gap before the next grant.
module sound_scheduler #(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned NREQ     = 4,
    parameter int unsigned GAP_MS   = 1,
    localparam int unsigned OwnerW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NREQ-1:0]     req_i,
    input  logic [3*NREQ-1:0]   note_i,
    input  logic [8*NREQ-1:0]   dur_i,
    input  logic                stop_all_i,
    output logic [NREQ-1:0]     ack_o,
    output logic [NREQ-1:0]     done_o,
    output logic [4:0]          tone_sel_o,
    output logic                busy_o,
    output logic [OwnerW-1:0]   owner_o
);

    localparam int unsigned Tick    = CLK_FREQ / 1000;
    localparam int unsigned PreW    = (Tick > 1) ? $clog2(Tick) : 1;
    localparam logic [PreW-1:0] TickMax = PreW'(Tick - 1);
    localparam logic [7:0]  GapMs   = 8'(GAP_MS);
    localparam bit          NoGap   = (GAP_MS == 0);

    typedef enum logic [1:0] {StIdle, StPlay, StGap} state_e;

    state_e              state_q;
    logic [PreW-1:0]     presc_q;
    logic [7:0]          ms_q;
    logic [NREQ-1:0]     ack_q;
    logic [NREQ-1:0]     done_q;
    logic [4:0]          tone_q;
    logic                busy_q;
    logic [OwnerW-1:0]   owner_q;

    logic [OwnerW-1:0]   gnt_idx;
    logic [NREQ-1:0]     gnt_oh;
    logic [2:0]          gnt_note;
    logic [7:0]          gnt_dur;
    logic [7:0]          gnt_dur_fix;
    logic [NREQ-1:0]     own_oh;
    logic                any_req;

    function automatic logic [4:0] decode_note(input logic [2:0] n);
        logic [4:0] t;
        case (n)
            3'd1:    t = 5'b00001;
            3'd2:    t = 5'b00010;
            3'd3:    t = 5'b00100;
            3'd4:    t = 5'b01000;
            3'd5:    t = 5'b10000;
            default: t = 5'b00000;
        endcase
        return t;
    endfunction

    // Scan from the top so the lowest asserted index wins.
    always_comb begin
        gnt_idx  = '0;
        gnt_oh   = '0;
        gnt_note = '0;
        gnt_dur  = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                gnt_idx    = OwnerW'(i);
                gnt_oh     = '0;
                gnt_oh[i]  = 1'b1;
                gnt_note   = note_i[3*i +: 3];
                gnt_dur    = dur_i[8*i +: 8];
            end
        end
    end

    always_comb begin
        own_oh          = '0;
        own_oh[owner_q] = 1'b1;
    end

    assign any_req     = |req_i;
    assign gnt_dur_fix = (gnt_dur == 8'd0) ? 8'd1 : gnt_dur;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            presc_q <= '0;
            ms_q    <= '0;
            ack_q   <= '0;
            done_q  <= '0;
            tone_q  <= '0;
            busy_q  <= 1'b0;
            owner_q <= '0;
        end else begin
            ack_q  <= '0;
            done_q <= '0;
            unique case (state_q)
                StIdle: begin
                    if (any_req && !stop_all_i) begin
                        state_q <= StPlay;
                        owner_q <= gnt_idx;
                        ack_q   <= gnt_oh;
                        tone_q  <= decode_note(gnt_note);
                        busy_q  <= 1'b1;
                        ms_q    <= gnt_dur_fix;
                        presc_q <= TickMax;
                    end
                end
                StPlay: begin
                    if (stop_all_i) begin
                        state_q <= StIdle;
                        tone_q  <= '0;
                        busy_q  <= 1'b0;
                        presc_q <= '0;
                        ms_q    <= '0;
                    end else if (presc_q == '0) begin
                        if (ms_q == 8'd1) begin
                            done_q <= own_oh;
                            tone_q <= '0;
                            if (NoGap) begin
                                state_q <= StIdle;
                                busy_q  <= 1'b0;
                                ms_q    <= '0;
                                presc_q <= '0;
                            end else begin
                                // Gap reuses the same ms/prescaler counters.
                                state_q <= StGap;
                                ms_q    <= GapMs;
                                presc_q <= TickMax;
                            end
                        end else begin
                            ms_q    <= ms_q - 8'd1;
                            presc_q <= TickMax;
                        end
                    end else begin
                        presc_q <= presc_q - 1'b1;
                    end
                end
                StGap: begin
                    if (stop_all_i) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                        presc_q <= '0;
                        ms_q    <= '0;
                    end else if (presc_q == '0) begin
                        if (ms_q == 8'd1) begin
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                            ms_q    <= '0;
                            presc_q <= '0;
                        end else begin
                            ms_q    <= ms_q - 8'd1;
                            presc_q <= TickMax;
                        end
                    end else begin
                        presc_q <= presc_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    tone_q  <= '0;
                end
            endcase
        end
    end

    assign ack_o      = ack_q;
    assign done_o     = done_q;
    assign tone_sel_o = tone_q;
    assign busy_o     = busy_q;
    assign owner_o    = owner_q;

endmodule

// File: tb/tb_sound_scheduler.sv
// Directed bench for sound_scheduler with TICK=4, four requesters and a 1 ms gap.
module tb_sound_scheduler;

    localparam int unsigned NREQ = 4;

    logic              clk_i;
    logic              rst_ni;
    logic [NREQ-1:0]   req_i;
    logic [3*NREQ-1:0] note_i;
    logic [8*NREQ-1:0] dur_i;
    logic              stop_all_i;
    logic [NREQ-1:0]   ack_o;
    logic [NREQ-1:0]   done_o;
    logic [4:0]        tone_sel_o;
    logic              busy_o;
    logic [1:0]        owner_o;

    int checks = 0;
    int errors = 0;

    sound_scheduler #(
        .CLK_FREQ (4000),
        .NREQ     (NREQ),
        .GAP_MS   (1)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .req_i      (req_i),
        .note_i     (note_i),
        .dur_i      (dur_i),
        .stop_all_i (stop_all_i),
        .ack_o      (ack_o),
        .done_o     (done_o),
        .tone_sel_o (tone_sel_o),
        .busy_o     (busy_o),
        .owner_o    (owner_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy_o !== 1'b0 && n < 100) begin
            step();
            n++;
        end
        chk("wait_idle_busy", 32'(busy_o), 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ack"},   32'(ack_o), 32'd0);
        chk({tag, "_done"},  32'(done_o), 32'd0);
        chk({tag, "_tone"},  32'(tone_sel_o), 32'd0);
        chk({tag, "_busy"},  32'(busy_o), 32'd0);
        chk({tag, "_owner"}, 32'(owner_o), 32'd0);
    endtask

    initial begin
        logic [NREQ-1:0] done_seen;
        rst_ni     = 1'b1;
        req_i      = '0;
        note_i     = '0;
        dur_i      = '0;
        stop_all_i = 1'b0;
        #2 rst_ni  = 1'b0;

        // Reset values with all requests pending
        req_i = 4'b1111;
        note_i[2:0] = 3'd1;
        dur_i[7:0]  = 8'd1;
        step(); step(); step();
        chk_all_zero("reset");
        rst_ni = 1'b1;
        step();
        chk("rst_rel_ack", 32'(ack_o), 32'h1);
        chk("rst_rel_tone", 32'(tone_sel_o), 32'h01);
        req_i = '0;
        step();
        chk("rst_rel_ack_one_cycle", 32'(ack_o), 32'h0);
        wait_idle();

        // Single note on requester 2: note 3, dur 2
        note_i[8:6]  = 3'd3;
        dur_i[23:16] = 8'd2;
        req_i = 4'b0100;
        step();
        chk("single_ack", 32'(ack_o), 32'h4);
        chk("single_owner", 32'(owner_o), 32'd2);
        chk("single_busy", 32'(busy_o), 32'd1);
        chk("single_tone_c1", 32'(tone_sel_o), 32'h04);
        req_i = '0;
        for (int c = 2; c <= 8; c++) begin
            step();
            chk("single_tone_play", 32'(tone_sel_o), 32'h04);
            chk("single_ack_low", 32'(ack_o), 32'h0);
            chk("single_done_low", 32'(done_o), 32'h0);
        end
        step();
        chk("single_done_c9", 32'(done_o), 32'h4);
        chk("single_tone_c9", 32'(tone_sel_o), 32'h0);
        chk("single_busy_c9", 32'(busy_o), 32'd1);
        for (int c = 10; c <= 12; c++) begin
            step();
            chk("single_gap_tone", 32'(tone_sel_o), 32'h0);
            chk("single_gap_busy", 32'(busy_o), 32'd1);
            chk("single_gap_done", 32'(done_o), 32'h0);
        end
        step();
        chk("single_busy_c13", 32'(busy_o), 32'd0);

        // Simultaneous requests 1 and 3; requester 3 keeps req high
        note_i[5:3]   = 3'd1;
        dur_i[15:8]   = 8'd2;
        note_i[11:9]  = 3'd5;
        dur_i[31:24]  = 8'd2;
        req_i = 4'b1010;
        step();
        chk("simul_ack1", 32'(ack_o), 32'h2);
        chk("simul_owner1", 32'(owner_o), 32'd1);
        chk("simul_tone1", 32'(tone_sel_o), 32'h01);
        req_i = 4'b1000;
        for (int c = 2; c <= 13; c++) begin
            step();
            chk("simul_no_ack", 32'(ack_o), 32'h0);
            if (c == 9) chk("simul_done1", 32'(done_o), 32'h2);
        end
        chk("simul_idle_c13", 32'(busy_o), 32'd0);
        step();
        chk("simul_ack3", 32'(ack_o), 32'h8);
        chk("simul_owner3", 32'(owner_o), 32'd3);
        chk("simul_tone3_c14", 32'(tone_sel_o), 32'h10);
        req_i = '0;
        for (int c = 15; c <= 21; c++) begin
            step();
            chk("simul_tone3", 32'(tone_sel_o), 32'h10);
        end
        step();
        chk("simul_tone3_c22", 32'(tone_sel_o), 32'h0);
        chk("simul_done3_c22", 32'(done_o), 32'h8);
        wait_idle();

        // Rest note with zero duration on requester 0
        note_i[2:0] = 3'd7;
        dur_i[7:0]  = 8'd0;
        req_i = 4'b0001;
        step();
        chk("rest_ack", 32'(ack_o), 32'h1);
        req_i = '0;
        for (int c = 1; c <= 4; c++) begin
            if (c > 1) step();
            chk("rest_tone", 32'(tone_sel_o), 32'h0);
            chk("rest_busy", 32'(busy_o), 32'd1);
            chk("rest_done_low", 32'(done_o), 32'h0);
        end
        step();
        chk("rest_done_c5", 32'(done_o), 32'h1);
        wait_idle();

        // Abort during a dur=5 note, requester 1 pending
        note_i[2:0] = 3'd2;
        dur_i[7:0]  = 8'd5;
        note_i[5:3] = 3'd4;
        dur_i[15:8] = 8'd1;
        req_i = 4'b0001;
        step();
        chk("abort_ack0", 32'(ack_o), 32'h1);
        req_i = 4'b0010;
        step(); step(); step();
        chk("abort_tone_c4", 32'(tone_sel_o), 32'h02);
        stop_all_i = 1'b1;
        step();
        stop_all_i = 1'b0;
        chk("abort_tone_c5", 32'(tone_sel_o), 32'h0);
        chk("abort_busy_c5", 32'(busy_o), 32'd0);
        chk("abort_done_c5", 32'(done_o), 32'h0);
        chk("abort_ack_c5", 32'(ack_o), 32'h0);
        step();
        chk("abort_ack1_c6", 32'(ack_o), 32'h2);
        chk("abort_owner_c6", 32'(owner_o), 32'd1);
        chk("abort_tone_c6", 32'(tone_sel_o), 32'h08);
        chk("abort_done_c6", 32'(done_o), 32'h0);
        req_i = '0;
        for (int c = 7; c <= 14; c++) begin
            step();
            if (c < 10) chk("abort_play1_tone", 32'(tone_sel_o), 32'h08);
            if (c == 10) chk("abort_done1_c10", 32'(done_o), 32'h2);
        end
        wait_idle();

        // Asynchronous reset in the middle of a note
        note_i[8:6]  = 3'd4;
        dur_i[23:16] = 8'd3;
        req_i = 4'b0100;
        step();
        chk("midrst_ack", 32'(ack_o), 32'h4);
        chk("midrst_owner", 32'(owner_o), 32'd2);
        req_i = '0;
        step(); step();
        chk("midrst_tone_c3", 32'(tone_sel_o), 32'h08);
        #2 rst_ni = 1'b0;
        #1;
        chk_all_zero("midrst_async");
        step();
        rst_ni = 1'b1;
        done_seen = '0;
        for (int c = 0; c < 20; c++) begin
            step();
            done_seen |= done_o;
            chk("midrst_busy_after", 32'(busy_o), 32'd0);
        end
        chk("midrst_no_done", 32'(done_seen), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sound_scheduler.md
# sound_scheduler

Arbitrates and sequences tone requests from several game sources (song lane, hit feedback, miss buzz, menu click) onto the single 5-note tone path. Its one-hot `tone_sel` output uses the same encoding as the existing sound selector's `songD` input and drives that input directly. Each granted request plays for a programmed number of milliseconds, followed by a fixed silent gap. Requesters then receive a completion pulse.

## Interface
- `CLK_FREQ`, 50_000_000: clock frequency in Hz; `TICK = CLK_FREQ/1000` cycles per ms.
- `NREQ`, 4: number of requesters, 2..8.
- `GAP_MS`, 1: silent gap after each note in ms, 0..15.

- `clk`  in  1: system clock, rising edge.
- `rst_n`  in  1: asynchronous active-low reset.
- `req`  in  NREQ: request level per requester; `note`/`dur` must be stable while high.
- `note`  in  3*NREQ: note code, slice i = `[3i+2:3i]`; 1..5 select tones A..E; 0, 6 and 7 mean rest.
- `dur`  in  8*NREQ: duration in ms, slice i = `[8i+7:8i]`; 0 is treated as 1.
- `stop_all`  in  1: synchronous abort, e.g. game over.
- `ack`  out  NREQ: one-cycle grant pulse.
- `done`  out  NREQ: one-cycle completion pulse.
- `tone_sel`  out  5: one-hot tone select. Note 1 → `5'b00001`, 2 → `00010`, 3 → `00100`, 4 → `01000`, 5 → `10000`; rest → `0`.
- `busy`  out  1: high in PLAY or GAP.
- `owner`  out  `max(1,$clog2(NREQ))`: index of the current or last granted requester.

## Operation
- FSM states: IDLE, PLAY, GAP.
- **IDLE**
  - If any `req` bit is high, grant the lowest index i (fixed priority, non-preemptive).
  - Latch `note[i]` and `dur[i]` (0 becomes 1); set `owner`←i and `ack[i]`←1.
  - Load the ms counter with dur and the prescaler with TICK-1; go to PLAY.
- **PLAY**
  - `tone_sel` holds the decoded latched note.
  - The prescaler counts down; at 0 it reloads TICK-1 and the ms counter decrements.
  - When the ms counter reaches 0 on a tick, go to GAP. If `GAP_MS`=0, go straight to IDLE instead.
  - `done[owner]`←1 on this transition.
- **GAP**
  - `tone_sel`=0 for `GAP_MS`*TICK cycles, then go to IDLE.
- `stop_all` sampled high in PLAY or GAP → IDLE next cycle, `tone_sel`←0, no `done`. In IDLE it blocks grants that cycle.
- Requesters must drop `req` after `ack`. A `req` still high when the FSM is next in IDLE is a new request (retrigger).
- Changes to `note`/`dur` after grant have no effect.
- Counters: prescaler width `$clog2(TICK)`; ms counter 8 bits. No overflow is possible (maximum 255 ms per note).
- Lower-index requesters can starve higher ones; this is intended (song lane = index 0).

## Timing
- Reset (async, `rst_n` low): state IDLE; `ack`, `done`, `tone_sel`, `busy`, `owner` all 0; counters 0. Takes effect mid-note with no `done`.
- All outputs are registered.
- Grant latency: request sampled in IDLE at cycle T → `ack`, `busy` and `tone_sel` valid at T+1.
- Note length: `tone_sel` is held exactly dur*TICK cycles (T+1 .. T+dur*TICK).
- `done` is high in the first cycle after PLAY, which is the first GAP cycle or the first IDLE cycle.
- GAP lasts exactly `GAP_MS`*TICK cycles; `busy` falls in the first IDLE cycle.
- Back-to-back requests: a new grant is sampled in the first IDLE cycle and acked one cycle later. With `GAP_MS`=0 the minimum silence between notes is 1 cycle.
- `stop_all` response latency is 1 cycle.

## Test plan
Bench parameters: `CLK_FREQ`=4000 (TICK=4), `NREQ`=4, `GAP_MS`=1.
- **Reset values:** assert `rst_n`=0 with `req`=4'b1111 → all outputs 0; release → `ack[0]` one cycle later.
- **Single note:** `req[2]` at cycle 0 with note=3, dur=2, dropped after `ack` → `ack[2]`=1 at cycle 1 only; `tone_sel`=00100 cycles 1–8; `done[2]` at cycle 9; `tone_sel`=0 cycles 9–12; `busy`=0 at cycle 13.
- **Simultaneous requests:** `req[1]` and `req[3]` at cycle 0, both dur=2, `req[3]` held → `ack[1]` at 1, `owner`=1; `ack[3]` at 14, `owner`=3, `tone_sel` per `note[3]` cycles 14–21.
- **Rest and zero duration:** note=7, dur=0 → `tone_sel`=0 but `busy`=1 cycles 1–4; `done` at 5.
- **Abort:** `stop_all` pulsed at cycle 4 during a dur=5 note → `tone_sel`=0 and `busy`=0 at cycle 5; no `done`; a pending `req` is acked at 6.
- **Mid-note reset:** `rst_n` pulled low at cycle 3 of a note → outputs 0 asynchronously; no `done` after release.
